sipo: RTL and testbench
=======================

Name: sipo

Overview:
Serial-in parallel-out deserializer, the receive-side counterpart to the team's PISO shift register. It consumes a qualified bit stream (bit + valid) and assembles DATA_WIDTH-bit words. Bit order is selectable. Each completed word is presented on a one-deep output register with a valid/ready handshake. A word that arrives while the output register is still full is dropped and flagged.

Parameters:
DATA_WIDTH, 8, word width in bits; legal values are >= 2.
DIRECTION, "msb_first", order of the incoming bits: "msb_first" or "lsb_first".

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
a_rst_i  input  1  asynchronous, active-high reset.
en_i  input  1  global enable; while low, no serial bit is accepted.
clr_i  input  1  synchronous frame resync; discards the partial word.
data_valid_i  input  1  qualifies data_i for this cycle.
data_i  input  1  serial bit.
data_o  output  DATA_WIDTH  assembled word.
data_valid_o  output  1  data_o holds an unconsumed word.
data_ready_i  input  1  consumer accepts data_o.
busy_o  output  1  a partial word is in progress (bit counter != 0).
overflow_o  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (asynchronous, active-high): data_o=0, data_valid_o=0, overflow_o=0, busy_o=0, shift reg=0, bit counter=0. Takes effect immediately, including mid-word.
- Bit accept: a bit is accepted when en_i=1, data_valid_i=1 and clr_i=0.
- Shift on msb_first: sh <= {sh[W-2:0], data_i}. The first bit received ends up as data_o[W-1].
- Shift on lsb_first: sh <= {data_i, sh[W-1:1]}. The first bit received ends up as data_o[0].
- Bit counter: width $clog2(DATA_WIDTH), increments per accepted bit. On the accept with cnt==W-1 it wraps to 0, which marks word completion.
- Word completion: the completed word is {sh, final bit} shifted per DIRECTION.
- Load rule: the word loads data_o if the slot is free or draining this cycle, i.e. data_valid_o==0, or data_valid_o==1 with data_ready_i==1.
  - On load: data_valid_o=1 on the next clock edge. Latency is 1 clock from the final-bit edge.
  - Otherwise: the word is discarded, data_o is unchanged, and overflow_o=1 for exactly 1 cycle.
- Handshake:
  - Transfer occurs on a clock edge where data_valid_o && data_ready_i.
  - data_valid_o drops on the next edge unless a new word loads on that same edge; in that case it stays high and data_o updates. This gives back-to-back words with no bubble.
  - data_o is stable while data_valid_o=1 and data_ready_i=0.
  - data_ready_i while data_valid_o=0 has no effect.
- en_i=0 or data_valid_i=0: shift reg and counter hold. The output handshake continues independently of en_i.
- clr_i=1: shift reg and counter go to 0 on the next edge; any bit presented that cycle is discarded (clr_i wins). The output register and data_valid_o are unaffected.
- busy_o = (cnt != 0), registered state, no combinational path from inputs.
- overflow_o is registered. It is never asserted by clr_i or by reset.

Decomposition:
- Shared package serial_pkg holds:
  - string constants DIR_MSB_FIRST="msb_first" and DIR_LSB_FIRST="lsb_first", shared with piso.
  - localparam function for the counter width, max(1, $clog2(W)).
- No sub-module. Single module with a generate split on DIRECTION for the shift expression, mirroring piso.
- Elaboration-time check: DATA_WIDTH >= 2 and DIRECTION is one of the two legal strings; fatal otherwise.

Test Plan:
1. W=8, msb_first, ready=1: 0xA5 sent 1,0,1,0,0,1,0,1 on consecutive cycles -> data_o=0xA5 and data_valid_o=1 one edge after the 8th bit, high for 1 cycle. busy_o=1 after bits 1-7, then 0.
2. W=8, lsb_first: 0xA5 sent 1,0,1,0,0,1,0,1 (LSB first) -> data_o=0xA5. Then 0x01 sent 1,0,0,0,0,0,0,0 -> data_o=0x01.
3. Backpressure, ready=0: stream 0x3C then 0xC3 -> data_o holds 0x3C and overflow_o pulses once after the 16th bit. Raising ready transfers 0x3C, then data_valid_o=0; 0xC3 never appears.
4. Drain coincides with completion: ready asserted exactly on the edge the 2nd word completes -> 0x3C then 0xC3 back-to-back, data_valid_o continuously 1, no overflow.
5. Gaps and resync:
   - data_valid_i and en_i randomly low between bits of 0x5A -> data_o=0x5A.
   - clr_i after 3 bits of garbage, then 0x81 -> data_o=0x81, with a bit presented in the clr_i cycle discarded.
6. Reset mid-operation: assert a_rst_i asynchronously (between edges) after 5 bits with data_valid_o=1 -> all outputs 0 immediately. After release, a full 0x0F is received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift blocks (sipo / piso).
package serial_pkg;

   // Legal values for the DIRECTION parameter of the serial blocks.
   localparam string DIR_MSB_FIRST = "msb_first";
   localparam string DIR_LSB_FIRST = "lsb_first";

   // Bit-counter width for a W-bit word. It is never narrower than one bit.
   function automatic int cnt_width(input int w);
      return ($clog2(w) > 1) ? $clog2(w) : 1;
   endfunction

endpackage : serial_pkg

// File: rtl/sipo.sv
// Serial-in parallel-out deserializer.
// A qualified bit stream is assembled into DATA_WIDTH-bit words. Each word is
// placed in a one-deep output register that uses a valid/ready handshake. A
// completed word that finds the output slot full is dropped, and the drop is
// flagged with a one-cycle overflow pulse.
module sipo
   import serial_pkg::*;
#(
   parameter int    DATA_WIDTH = 8,
   parameter string DIRECTION  = DIR_MSB_FIRST
) (
   input  logic                  clk_i,
   input  logic                  a_rst_i,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  data_valid_i,
   input  logic                  data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic                  busy_o,
   output logic                  overflow_o
);

   localparam int              CNT_W    = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  vld_q, vld_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] shifted;
   logic                  accept;
   logic                  last_bit;
   logic                  slot_free;

   if (DATA_WIDTH < 2) begin : g_bad_width
      $fatal(1, "sipo: DATA_WIDTH must be >= 2");
   end

   // The shift expression is chosen from the bit order, in the same way as piso.
   if (DIRECTION == DIR_MSB_FIRST) begin : g_msb
      assign shifted = {sh_q[DATA_WIDTH-2:0], data_i};
   end else if (DIRECTION == DIR_LSB_FIRST) begin : g_lsb
      assign shifted = {data_i, sh_q[DATA_WIDTH-1:1]};
   end else begin : g_bad_dir
      $fatal(1, "sipo: DIRECTION must be \"msb_first\" or \"lsb_first\"");
      assign shifted = '0;
   end

   assign accept    = en_i && data_valid_i && !clr_i;
   assign last_bit  = accept && (cnt_q == CNT_LAST);
   assign slot_free = !vld_q || data_ready_i;

   // Next state for the assembly path and the output slot.
   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      vld_d  = vld_q;
      ovf_d  = 1'b0;

      // A resync (clr_i) takes priority over any bit presented in the same cycle.
      if (clr_i) begin
         sh_d  = '0;
         cnt_d = '0;
      end else if (accept) begin
         sh_d  = shifted;
         cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      end

      // The output slot empties when a word is taken, and can be refilled on the same edge.
      if (vld_q && data_ready_i) begin
         vld_d = 1'b0;
      end
      if (last_bit) begin
         if (slot_free) begin
            data_d = shifted;
            vld_d  = 1'b1;
         end else begin
            ovf_d  = 1'b1;
         end
      end
   end

   // State registers, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = vld_q;
   assign busy_o       = (cnt_q != '0);
   assign overflow_o   = ovf_q;

endmodule : sipo

// File: tb/tb_sipo.sv
// Directed testbench for sipo. It uses one msb_first instance and one lsb_first instance.
module tb_sipo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       dv = 1'b0;
   logic       din = 1'b0;
   logic       rdy = 1'b0;
   logic [7:0] m_data, l_data;
   logic       m_vld, l_vld, m_busy, l_busy, m_ovf, l_ovf;

   int checks = 0;
   int failures = 0;

   sipo #(.DATA_WIDTH(8), .DIRECTION("msb_first")) u_msb (
      .clk_i(clk), .a_rst_i(rst), .en_i(en), .clr_i(clr),
      .data_valid_i(dv), .data_i(din), .data_o(m_data),
      .data_valid_o(m_vld), .data_ready_i(rdy), .busy_o(m_busy),
      .overflow_o(m_ovf)
   );

   sipo #(.DATA_WIDTH(8), .DIRECTION("lsb_first")) u_lsb (
      .clk_i(clk), .a_rst_i(rst), .en_i(en), .clr_i(clr),
      .data_valid_i(dv), .data_i(din), .data_o(l_data),
      .data_valid_o(l_vld), .data_ready_i(rdy), .busy_o(l_busy),
      .overflow_o(l_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then wait 1 time unit. Inputs are driven and outputs
   // are sampled at this point, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; dv = 1'b0; clr = 1'b0; din = 1'b0;
      step();
   endtask

   task automatic send_bit(input logic b);
      en = 1'b1; dv = 1'b1; clr = 1'b0; din = b;
      step();
   endtask

   // Send an 8-bit value in the given order. The first bit is v[7] when lsb=0 and v[0] when lsb=1.
   task automatic send_word(input logic [7:0] v, input bit lsb);
      for (int i = 0; i < 8; i++) send_bit(lsb ? v[i] : v[7-i]);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      step();
      #2 rst = 1'b0;
      en = 1'b0; dv = 1'b0; clr = 1'b0; din = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] v;

      // Reset state
      do_reset();
      check("rst_data", m_data, 8'h00);
      check("rst_vld", m_vld, 1'b0);
      check("rst_busy", m_busy, 1'b0);
      check("rst_ovf", m_ovf, 1'b0);

      // 1: msb_first 0xA5 with ready=1
      rdy = 1'b1;
      v = 8'hA5;
      for (int i = 0; i < 7; i++) begin
         send_bit(v[7-i]);
         check("t1_busy_mid", m_busy, 1'b1);
         check("t1_vld_mid", m_vld, 1'b0);
      end
      send_bit(v[0]);
      check("t1_data", m_data, 8'hA5);
      check("t1_vld", m_vld, 1'b1);
      check("t1_busy_end", m_busy, 1'b0);
      idle();
      check("t1_vld_drop", m_vld, 1'b0);
      check("t1_ovf", m_ovf, 1'b0);

      // 2: lsb_first 0xA5, then 0x01
      do_reset();
      rdy = 1'b1;
      send_word(8'hA5, 1'b1);
      check("t2_data_a5", l_data, 8'hA5);
      check("t2_vld_a5", l_vld, 1'b1);
      send_word(8'h01, 1'b1);
      check("t2_data_01", l_data, 8'h01);
      check("t2_vld_01", l_vld, 1'b1);

      // 3: backpressure, so the second word is dropped
      do_reset();
      rdy = 1'b0;
      send_word(8'h3C, 1'b0);
      check("t3_data_w1", m_data, 8'h3C);
      check("t3_vld_w1", m_vld, 1'b1);
      check("t3_ovf_w1", m_ovf, 1'b0);
      send_word(8'hC3, 1'b0);
      check("t3_ovf_pulse", m_ovf, 1'b1);
      check("t3_data_hold", m_data, 8'h3C);
      idle();
      check("t3_ovf_clear", m_ovf, 1'b0);
      check("t3_data_stable", m_data, 8'h3C);
      rdy = 1'b1;
      idle();
      check("t3_vld_after_xfer", m_vld, 1'b0);
      idle();
      check("t3_vld_stays_low", m_vld, 1'b0);
      check("t3_no_c3", m_data, 8'h3C);

      // 4: the drain happens on the same edge as the second word completes
      do_reset();
      rdy = 1'b0;
      send_word(8'h3C, 1'b0);
      check("t4_data_w1", m_data, 8'h3C);
      v = 8'hC3;
      for (int i = 0; i < 7; i++) begin
         send_bit(v[7-i]);
         check("t4_vld_cont", m_vld, 1'b1);
      end
      rdy = 1'b1;
      send_bit(v[0]);
      check("t4_vld_b2b", m_vld, 1'b1);
      check("t4_data_w2", m_data, 8'hC3);
      check("t4_no_ovf", m_ovf, 1'b0);
      idle();
      check("t4_vld_drop", m_vld, 1'b0);
      check("t4_no_ovf_late", m_ovf, 1'b0);

      // 5a: gaps in data_valid_i and en_i
      do_reset();
      rdy = 1'b1;
      v = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         en = 1'b1; dv = 1'b0; din = ~v[7-i]; step();
         en = 1'b0; dv = 1'b1; din = ~v[7-i]; step();
         if (i % 3 == 0) begin
            en = 1'b0; dv = 1'b0; din = 1'b1; step();
         end
         send_bit(v[7-i]);
      end
      check("t5_data_5a", m_data, 8'h5A);
      check("t5_vld_5a", m_vld, 1'b1);
      idle();

      // 5b: clr_i after three garbage bits. The bit presented with clr_i is discarded.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      check("t5_busy_garbage", m_busy, 1'b1);
      en = 1'b1; dv = 1'b1; clr = 1'b1; din = 1'b1;
      step();
      clr = 1'b0;
      check("t5_busy_clr", m_busy, 1'b0);
      check("t5_vld_clr", m_vld, 1'b0);
      send_word(8'h81, 1'b0);
      check("t5_data_81", m_data, 8'h81);
      check("t5_vld_81", m_vld, 1'b1);

      // 6: asynchronous reset mid-word while data_valid_o is high
      do_reset();
      rdy = 1'b0;
      send_word(8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check("t6_vld_before", m_vld, 1'b1);
      check("t6_busy_before", m_busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_data", m_data, 8'h00);
      check("t6_rst_vld", m_vld, 1'b0);
      check("t6_rst_busy", m_busy, 1'b0);
      check("t6_rst_ovf", m_ovf, 1'b0);
      #1 rst = 1'b0;
      en = 1'b0; dv = 1'b0;
      step();
      rdy = 1'b1;
      send_word(8'h0F, 1'b0);
      check("t6_data_0f", m_data, 8'h0F);
      check("t6_vld_0f", m_vld, 1'b1);
      check("t6_ovf_0f", m_ovf, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sipo
